// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants and the fetch-queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: reset PC, instruction-memory window, and the 65-bit queue entry
// (pc, instr, adel) stored by fetch_queue.
package fetch_queue_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IMEM_LIMIT = 32'h0000_6FFC;

  localparam int ENTRY_W = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

endpackage

// File: rtl/fetch_queue_pc_range_check.sv
// Flags an instruction-fetch address error for a PC.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: pc (in, 32) -> adel (out, 1). adel is set for a misaligned PC or one
// outside [IMEM_BASE, IMEM_LIMIT]. Shared with the exception stage.
module pc_range_check
  import fetch_queue_pkg::*;
(
  input  logic [31:0] pc,
  output logic        adel
);

  assign adel = (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_LIMIT);

endmodule

// File: rtl/fetch_queue.sv
// In-order queue between fetch and decode, holding DEPTH entries.
// Latency: one cycle push-to-head (no empty bypass).
// Backpressure: in_ready = (count < DEPTH) from registered state only; flush drops everything.
//
// Ports: clk, reset (sync, active high); in_valid/in_pc/in_instr/in_ready from
// fetch; out_valid/out_pc/out_instr/out_adel/out_ready to decode; flush on a
// redirect; count = number of held entries.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_adel,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           push;
  logic           pop;
  logic           in_adel;
  entry_t         head;

  // Error bit is decided at push time so later PC changes cannot affect it.
  pc_range_check u_pc_range_check (
    .pc   (in_pc),
    .adel (in_adel)
  );

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);

  assign push = in_valid && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; a slot is only read while count says it is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, adel: in_adel};
    end
  end

  // An empty queue presents a bubble: reset PC with a nop.
  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head.pc    : PC_RESET;
  assign out_instr = out_valid ? head.instr : 32'h0;
  assign out_adel  = out_valid && head.adel;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of pushed entries plus
// directed checks of reset, backpressure, wrap, flush, address errors and
// mid-stream reset.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;
  logic        out_ready;
  logic        flush;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;

  entry_t sb[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_adel  (out_adel),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  function automatic logic ref_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle with inputs already driven. Handshakes come from the
  // scoreboard occupancy, not from the DUT's own outputs.
  task automatic tick();
    bit     push_ev;
    bit     pop_ev;
    entry_t exp;
    int     n;
    n = sb.size();
    check("in_ready_pre", 32'(in_ready), 32'(n < DEPTH));
    check("out_valid_pre", 32'(out_valid), 32'(n != 0));
    push_ev = !reset && !flush && in_valid && (n < DEPTH);
    pop_ev  = !reset && !flush && out_ready && (n != 0);
    if (pop_ev) begin
      exp = sb.pop_front();
      check("pop_pc", out_pc, exp.pc);
      check("pop_instr", out_instr, exp.instr);
      check("pop_adel", 32'(out_adel), 32'(exp.adel));
    end
    if (reset || flush) begin
      sb.delete();
    end else if (push_ev) begin
      sb.push_back('{pc: in_pc, instr: in_instr, adel: ref_adel(in_pc)});
    end
    @(posedge clk);
    @(negedge clk);
    check("count", 32'(count), 32'(sb.size()));
    if (sb.size() == 0) begin
      check("bubble_pc", out_pc, 32'h0000_3000);
      check("bubble_instr", out_instr, 32'h0);
      check("bubble_adel", 32'(out_adel), 32'h0);
    end else begin
      check("head_pc", out_pc, sb[0].pc);
      check("head_adel", 32'(out_adel), 32'(sb[0].adel));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = pc ^ 32'hA5A5_0000;
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_count", 32'(count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_pc", out_pc, 32'h0000_3000);
    check("rst_out_instr", out_instr, 32'h0);

    // First push becomes visible the following cycle.
    drive(1'b1, 32'h0000_3000, 1'b0);
    in_instr = 32'h3401_0001;
    check("no_bypass", 32'(out_valid), 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("first_valid", 32'(out_valid), 32'h1);
    check("first_pc", out_pc, 32'h0000_3000);
    check("first_instr", out_instr, 32'h3401_0001);
    check("first_count", 32'(count), 32'h1);
    check("first_adel", 32'(out_adel), 32'h0);
    tick();
    check("stall_pc", out_pc, 32'h0000_3000);
    drive(1'b0, 32'h0, 1'b1);
    tick();

    // Fill to DEPTH; the third entry is held off.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_3000 + 32'(4 * i), 1'b0);
      tick();
    end
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_count", 32'(count), 32'h2);
    drive(1'b0, 32'h0, 1'b1);
    check("drain_first", out_pc, 32'h0000_3000);
    tick();
    check("drain_second", out_pc, 32'h0000_3004);
    tick();
    check("drained", 32'(count), 32'h0);

    // Streaming at count=1 across several pointer wraps.
    drive(1'b1, 32'h0000_3000, 1'b0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h0000_3000 + 32'(4 * i), 1'b1);
      tick();
      check("stream_count", 32'(count), 32'h1);
      check("stream_head", out_pc, 32'h0000_3000 + 32'(4 * i));
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();

    // Flush wins over a same-cycle push and pop.
    drive(1'b1, 32'h0000_4000, 1'b0); tick();
    drive(1'b1, 32'h0000_4004, 1'b0); tick();
    drive(1'b1, 32'h0000_4008, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", 32'(count), 32'h0);
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_pc", out_pc, 32'h0000_3000);
    drive(1'b0, 32'h0, 1'b1); tick();
    drive(1'b1, 32'h0000_5000, 1'b0); tick();
    check("post_flush_head", out_pc, 32'h0000_5000);
    drive(1'b0, 32'h0, 1'b1); tick();

    // Address-error classification, including the last legal word.
    begin
      logic [31:0] pcs [4];
      logic        exp_e [4];
      pcs[0] = 32'h0000_3002; exp_e[0] = 1'b1;
      pcs[1] = 32'h0000_2FFC; exp_e[1] = 1'b1;
      pcs[2] = 32'h0000_7000; exp_e[2] = 1'b1;
      pcs[3] = 32'h0000_6FFC; exp_e[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, pcs[i], 1'b0);
        tick();
        check("adel", 32'(out_adel), 32'(exp_e[i]));
        drive(1'b0, 32'h0, 1'b1);
        tick();
      end
    end

    // Reset mid-stream beats push and pop.
    drive(1'b1, 32'h0000_3100, 1'b0); tick();
    drive(1'b1, 32'h0000_3104, 1'b0); tick();
    check("pre_reset_count", 32'(count), 32'h2);
    drive(1'b1, 32'h0000_3108, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h1);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    drive(1'b0, 32'h0, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 2: number of fetch entries held; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  fetch stage presents an entry this cycle.
REQ-005 in_pc  input  32  PC of the fetched instruction.
REQ-006 in_instr  input  32  fetched instruction word.
REQ-007 in_ready  output  1  queue accepts an entry this cycle.
REQ-008 out_valid  output  1  head entry is valid for decode.
REQ-009 out_pc  output  32  head entry PC.
REQ-010 out_instr  output  32  head entry instruction.
REQ-011 out_adel  output  1  head entry has an instruction-fetch address error.
REQ-012 out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 flush  input  1  branch or jump redirect; discard all held entries.
REQ-014 count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-016 in_ready SHALL equal (count < DEPTH), decoded from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count != 0); there is no empty bypass, so an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest.
REQ-018 Entries SHALL leave in push order; read and write pointers wrap modulo DEPTH.
REQ-019 Push and pop together with 0 < count < DEPTH SHALL leave count unchanged and keep the stream intact.
REQ-020 Push and pop together when count == DEPTH cannot occur, because in_ready is 0; the pop alone takes effect.
REQ-021 When count == 0, out_ready is ignored and count SHALL NOT underflow.
REQ-022 flush SHALL have priority over push and pop.
  - At the edge, count is set to 0 and both pointers to 0.
  - The entry offered in the same cycle is dropped.
  - out_valid is 0 in the next cycle.
REQ-023 The address-error bit SHALL be computed at push time and stored with the entry.
  - It is set when in_pc[1:0] != 0, when in_pc < IMEM_BASE, or when in_pc > IMEM_LIMIT.
REQ-024 out_adel SHALL equal the stored bit of the head entry, gated by out_valid.
REQ-025 When out_valid is 0, out_pc SHALL read PC_RESET and out_instr SHALL read 0 (nop), so decode sees a bubble.
REQ-026 Held entries SHALL remain stable while out_ready is 0 (stall).

Reset
REQ-027 On reset, count, both pointers, out_valid and out_adel SHALL be 0, and in_ready SHALL be 1.
REQ-028 On reset, out_pc SHALL read 0x00003000 and out_instr SHALL read 0.
REQ-029 Reset SHALL have priority over flush, push and pop, including when it is asserted mid-stream.

Structure
REQ-030 The shared CPU package SHALL hold PC_RESET = 32'h00003000, IMEM_BASE = 32'h00003000, IMEM_LIMIT = 32'h00006FFC and the entry width of 65 bits (pc, instr, adel).
REQ-031 The range test SHALL be the single combinational sub-module pc_range_check (pc in, adel out), so the exception stage can reuse it.

Verification
REQ-032 Reset release, then push pc 0x3000 / instr 0x34010001 with out_ready=0 -> next cycle out_valid=1, out_pc=0x3000, count=1, out_adel=0.
REQ-033 Push 0x3000, 0x3004, 0x3008 on back-to-back cycles with out_ready=0 -> in_ready=0 once count=2; 0x3008 is held off; with out_ready=1 the pops return 0x3000 then 0x3004.
REQ-034 Continuous push and pop at count=1 for 8 cycles, pc 0x3000 to 0x301C -> count stays 1, order is preserved, pointers wrap cleanly.
REQ-035 count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, out_pc=0x3000, and the in-flight entry never appears.
REQ-036 Push pc 0x3002, then 0x2FFC, then 0x7000 -> out_adel=1 for each; push 0x6FFC -> out_adel=0.
REQ-037 Assert reset for one cycle with count=2 and push and pop active -> next cycle count=0, in_ready=1, out_valid=0.
